// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi path-metric controller.
package viterbi_pkg;

  localparam int unsigned NSTATES   = 4;
  localparam int unsigned W_DEFAULT = 5;

  typedef logic [2:0] ctrl_state_t;

  localparam ctrl_state_t IDLE = 3'd0;
  localparam ctrl_state_t INIT = 3'd1;
  localparam ctrl_state_t RUN  = 3'd2;
  localparam ctrl_state_t TB   = 3'd3;
  localparam ctrl_state_t DONE = 3'd4;

  typedef logic [1:0] state_idx_t;

endpackage

// File: rtl/pm_min4.sv
// Combinational minimum and argmin of four metrics; lowest index wins ties.
module pm_min4
  import viterbi_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0] m0,
  input  logic [W-1:0] m1,
  input  logic [W-1:0] m2,
  input  logic [W-1:0] m3,
  output logic [W-1:0] min_val,
  output state_idx_t   min_idx
);

  logic [W-1:0] min01, min23;
  logic         idx01, idx23;

  // Strict less-than keeps the lower index on equal values.
  always_comb begin
    idx01 = (m1 < m0);
    min01 = idx01 ? m1 : m0;
    idx23 = (m3 < m2);
    min23 = idx23 ? m3 : m2;
    if (min23 < min01) begin
      min_val = min23;
      min_idx = {1'b1, idx23};
    end else begin
      min_val = min01;
      min_idx = {1'b0, idx01};
    end
  end

endmodule

// File: rtl/metric_ctrl.sv
// Frame sequencer and normalizer driving the four path-metric register banks.
module metric_ctrl
  import viterbi_pkg::*;
#(
  parameter int unsigned W           = W_DEFAULT,
  parameter int unsigned FRAME_LEN   = 32,
  parameter int unsigned NORM_THRESH = 16,
  parameter int unsigned INIT_BIAS   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         sym_valid,
  output logic                         sym_ready,
  input  logic [W-1:0]                 acs_m0,
  input  logic [W-1:0]                 acs_m1,
  input  logic [W-1:0]                 acs_m2,
  input  logic [W-1:0]                 acs_m3,
  input  logic [W-1:0]                 pm0,
  input  logic [W-1:0]                 pm1,
  input  logic [W-1:0]                 pm2,
  input  logic [W-1:0]                 pm3,
  output logic [W-1:0]                 m_in0,
  output logic [W-1:0]                 m_in1,
  output logic [W-1:0]                 m_in2,
  output logic [W-1:0]                 m_in3,
  output logic                         step_en,
  output logic [$clog2(FRAME_LEN)-1:0] step_cnt,
  output logic                         tb_start,
  output state_idx_t                   best_state,
  input  logic                         tb_done,
  output logic                         frame_done,
  output logic                         busy,
  output logic                         ovf
);

  localparam int unsigned CW = $clog2(FRAME_LEN);

  ctrl_state_t   state_q, state_d;
  logic [CW-1:0] step_cnt_q;
  logic          tb_start_q, frame_done_q, busy_q, ovf_q;
  state_idx_t    best_q;

  logic [W-1:0] acs [NSTATES];
  logic [W-1:0] pm  [NSTATES];
  logic [W-1:0] nxt [NSTATES];
  logic [W-1:0] acs_min, sub, nxt_min_unused;
  state_idx_t   acs_arg_unused, nxt_best;
  logic         accept, last_step, any_max;

  assign acs[0] = acs_m0;
  assign acs[1] = acs_m1;
  assign acs[2] = acs_m2;
  assign acs[3] = acs_m3;
  assign pm[0]  = pm0;
  assign pm[1]  = pm1;
  assign pm[2]  = pm2;
  assign pm[3]  = pm3;

  pm_min4 #(.W(W)) u_acs_min (
    .m0      (acs_m0),
    .m1      (acs_m1),
    .m2      (acs_m2),
    .m3      (acs_m3),
    .min_val (acs_min),
    .min_idx (acs_arg_unused)
  );

  pm_min4 #(.W(W)) u_nxt_min (
    .m0      (nxt[0]),
    .m1      (nxt[1]),
    .m2      (nxt[2]),
    .m3      (nxt[3]),
    .min_val (nxt_min_unused),
    .min_idx (nxt_best)
  );

  assign accept    = (state_q == RUN) && sym_valid;
  assign last_step = (step_cnt_q == CW'(FRAME_LEN - 1));
  assign any_max   = (acs_m0 == '1) || (acs_m1 == '1) || (acs_m2 == '1) || (acs_m3 == '1);
  // Subtracting only when every metric is at or above the threshold cannot underflow.
  assign sub       = (32'(acs_min) >= NORM_THRESH) ? W'(NORM_THRESH) : '0;

  always_comb begin
    for (int i = 0; i < NSTATES; i++) nxt[i] = pm[i];
    if (state_q == INIT) begin
      nxt[0] = '0;
      for (int i = 1; i < NSTATES; i++) nxt[i] = W'(INIT_BIAS);
    end else if (accept) begin
      for (int i = 0; i < NSTATES; i++) nxt[i] = acs[i] - sub;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = RUN;
      RUN:     if (accept && last_step) state_d = TB;
      TB:      if (tb_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      step_cnt_q   <= '0;
      tb_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
      best_q       <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d == INIT) || (state_d == RUN) || (state_d == TB);
      tb_start_q   <= (state_q == RUN) && (state_d == TB);
      frame_done_q <= (state_d == DONE);
      if (state_q == INIT) begin
        step_cnt_q <= '0;
        ovf_q      <= 1'b0;
      end else if (accept) begin
        step_cnt_q <= last_step ? '0 : step_cnt_q + 1'b1;
        if (any_max) ovf_q <= 1'b1;
      end
      if ((state_q == RUN) && (state_d == TB)) best_q <= nxt_best;
    end
  end

  assign sym_ready  = (state_q == RUN);
  assign step_en    = accept;
  assign m_in0      = nxt[0];
  assign m_in1      = nxt[1];
  assign m_in2      = nxt[2];
  assign m_in3      = nxt[3];
  assign step_cnt   = step_cnt_q;
  assign tb_start   = tb_start_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign ovf        = ovf_q;
  assign best_state = best_q;

endmodule

// File: tb/tb_metric_ctrl.sv
// Bench for metric_ctrl: frame-level reference model checked every cycle plus directed literals.
module tb_metric_ctrl;

  localparam int W  = 5;
  localparam int FL = 4;
  localparam int NT = 16;
  localparam int IB = 8;

  typedef int quad_t[4];
  typedef enum int {M_IDLE, M_INIT, M_RUN, M_TB, M_DONE} mph_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, sym_valid = 1'b0, tb_done = 1'b0;
  logic [W-1:0] acs [4];
  logic [W-1:0] pm  [4];
  logic [W-1:0] m_in [4];
  logic       sym_ready, step_en, tb_start, frame_done, busy, ovf;
  logic [1:0] step_cnt, best_state;

  int n_vec = 0;
  int n_err = 0;

  metric_ctrl #(.W(W), .FRAME_LEN(FL), .NORM_THRESH(NT), .INIT_BIAS(IB)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .acs_m0     (acs[0]),
    .acs_m1     (acs[1]),
    .acs_m2     (acs[2]),
    .acs_m3     (acs[3]),
    .pm0        (pm[0]),
    .pm1        (pm[1]),
    .pm2        (pm[2]),
    .pm3        (pm[3]),
    .m_in0      (m_in[0]),
    .m_in1      (m_in[1]),
    .m_in2      (m_in[2]),
    .m_in3      (m_in[3]),
    .step_en    (step_en),
    .step_cnt   (step_cnt),
    .tb_start   (tb_start),
    .best_state (best_state),
    .tb_done    (tb_done),
    .frame_done (frame_done),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // The metric register bank the controller feeds.
  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 4; k++) pm[k] <= reset ? m_in[k] : '0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic quad_t normalize(input int a0, a1, a2, a3);
    quad_t r;
    int mn, s;
    mn = a0;
    if (a1 < mn) mn = a1;
    if (a2 < mn) mn = a2;
    if (a3 < mn) mn = a3;
    s = (mn >= NT) ? NT : 0;
    r[0] = a0 - s; r[1] = a1 - s; r[2] = a2 - s; r[3] = a3 - s;
    return r;
  endfunction

  function automatic int argmin(input quad_t v);
    int b = 0;
    for (int k = 1; k < 4; k++) if (v[k] < v[b]) b = k;
    return b;
  endfunction

  // Reference model state
  mph_t  ph = M_IDLE;
  quad_t exp_pm = '{0, 0, 0, 0};
  int    exp_cnt = 0, exp_best = 0;
  bit    exp_ovf = 0, exp_tbs = 0, exp_fd = 0, exp_busy = 0;
  mph_t  nph;
  quad_t npm;
  int    ncnt, nbest;
  bit    novf, ntbs, nfd;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph <= M_IDLE; exp_pm <= '{0, 0, 0, 0}; exp_cnt <= 0; exp_best <= 0;
      exp_ovf <= 0; exp_tbs <= 0; exp_fd <= 0; exp_busy <= 0;
    end else begin
      nph = ph; npm = exp_pm; ncnt = exp_cnt; nbest = exp_best; novf = exp_ovf;
      ntbs = 0; nfd = 0;
      case (ph)
        M_IDLE: if (start) nph = M_INIT;
        M_INIT: begin npm = '{0, IB, IB, IB}; ncnt = 0; novf = 0; nph = M_RUN; end
        M_RUN: if (sym_valid) begin
          npm = normalize(acs[0], acs[1], acs[2], acs[3]);
          for (int k = 0; k < 4; k++) if (acs[k] == 5'd31) novf = 1;
          ncnt = exp_cnt + 1;
          if (ncnt == FL) begin
            ncnt = 0; nph = M_TB; ntbs = 1; nbest = argmin(npm);
          end
        end
        M_TB:   if (tb_done) begin nph = M_DONE; nfd = 1; end
        M_DONE: nph = M_IDLE;
        default: nph = M_IDLE;
      endcase
      ph <= nph; exp_pm <= npm; exp_cnt <= ncnt; exp_best <= nbest; exp_ovf <= novf;
      exp_tbs <= ntbs; exp_fd <= nfd;
      exp_busy <= (nph == M_INIT) || (nph == M_RUN) || (nph == M_TB);
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    quad_t em;
    if (ph == M_INIT) em = '{0, IB, IB, IB};
    else if (ph == M_RUN && sym_valid) em = normalize(acs[0], acs[1], acs[2], acs[3]);
    else em = exp_pm;
    check("sym_ready", int'(sym_ready), int'(reset && ph == M_RUN));
    check("step_en", int'(step_en), int'(reset && ph == M_RUN && sym_valid));
    check("step_cnt", int'(step_cnt), exp_cnt);
    check("tb_start", int'(tb_start), int'(exp_tbs));
    check("best_state", int'(best_state), exp_best);
    check("frame_done", int'(frame_done), int'(exp_fd));
    check("busy", int'(busy), int'(exp_busy));
    check("ovf", int'(ovf), int'(exp_ovf));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("pm%0d", k), int'(pm[k]), exp_pm[k]);
      check($sformatf("m_in%0d", k), int'(m_in[k]), reset ? em[k] : 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acs(input int a0, a1, a2, a3);
    acs[0] = 5'(a0); acs[1] = 5'(a1); acs[2] = 5'(a2); acs[3] = 5'(a3);
  endtask

  task automatic accept(input int a0, a1, a2, a3);
    set_acs(a0, a1, a2, a3);
    sym_valid = 1'b1;
    cyc();
    sym_valid = 1'b0;
  endtask

  initial begin
    int got;
    set_acs(0, 0, 0, 0);
    #2 reset = 1'b0;
    repeat (2) cyc();
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(sym_ready), 0);
    reset = 1'b1;
    cyc();

    // Frame 1: start, INIT, then RUN
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("init_ready", int'(sym_ready), 0);
    check("init_m_in1", int'(m_in[1]), 8);
    cyc();
    check("run_ready", int'(sym_ready), 1);
    check("init_pm0", int'(pm[0]), 0);
    check("init_pm3", int'(pm[3]), 8);
    check("run_busy", int'(busy), 1);

    set_acs(3, 5, 7, 9);
    sym_valid = 1'b1;
    #1 check("acc1_step_en", int'(step_en), 1);
    check("acc1_m_in0", int'(m_in[0]), 3);
    cyc();
    sym_valid = 1'b0;
    check("acc1_pm1", int'(pm[1]), 5);
    check("acc1_cnt", int'(step_cnt), 1);
    repeat (3) cyc();
    check("hold_pm3", int'(pm[3]), 9);
    check("hold_cnt", int'(step_cnt), 1);
    check("hold_step_en", int'(step_en), 0);

    accept(18, 20, 17, 31);
    check("norm_pm0", int'(pm[0]), 2);
    check("norm_pm2", int'(pm[2]), 1);
    check("norm_pm3", int'(pm[3]), 15);
    check("ovf_set", int'(ovf), 1);
    accept(10, 12, 11, 13);
    check("nonorm_pm1", int'(pm[1]), 12);
    check("cnt3", int'(step_cnt), 3);

    accept(4, 1, 1, 6);
    check("tb_start", int'(tb_start), 1);
    check("tb_best", int'(best_state), 1);
    check("tb_cnt", int'(step_cnt), 0);
    check("tb_ready", int'(sym_ready), 0);

    // Inputs that must be ignored while in traceback
    set_acs(30, 30, 30, 30);
    sym_valid = 1'b1;
    start = 1'b1;
    repeat (4) cyc();
    check("tb_no_restart", int'(tb_start), 0);
    check("tb_hold_pm0", int'(pm[0]), 4);
    check("tb_step_en", int'(step_en), 0);
    sym_valid = 1'b0;
    start = 1'b0;
    tb_done = 1'b1;
    cyc();
    tb_done = 1'b0;
    check("frame_done", int'(frame_done), 1);
    check("done_busy", int'(busy), 0);
    check("ovf_sticky", int'(ovf), 1);
    tb_done = 1'b1;
    cyc();
    tb_done = 1'b0;
    check("fd_pulse", int'(frame_done), 0);
    cyc();

    // Frame 2: reset in mid-RUN
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check("ovf_cleared", int'(ovf), 0);
    accept(31, 20, 25, 18);
    check("f2_pm0", int'(pm[0]), 15);
    check("f2_pm3", int'(pm[3]), 2);
    accept(0, 1, 2, 3);
    check("f2_cnt", int'(step_cnt), 2);
    sym_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_ready", int'(sym_ready), 0);
    check("mid_rst_step_en", int'(step_en), 0);
    check("mid_rst_cnt", int'(step_cnt), 0);
    check("mid_rst_ovf", int'(ovf), 0);
    check("mid_rst_busy", int'(busy), 0);
    sym_valid = 1'b0;
    cyc();
    reset = 1'b1;
    repeat (2) cyc();
    check("post_rst_ready", int'(sym_ready), 0);
    check("post_rst_busy", int'(busy), 0);

    // Frame 3: tb_done held from the start, accepted in the first TB cycle
    tb_done = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    set_acs(1, 2, 3, 4);
    sym_valid = 1'b1;
    repeat (FL) cyc();
    sym_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      if (frame_done) got = 1;
      else cyc();
    end
    check("f3_frame_done_seen", got, 1);
    tb_done = 1'b0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
